// File: rtl/adc_axis_packer.sv
// Multi-channel ADC capture front end: packs PACK input words per AXI4-Stream beat,
// buffers beats in a first-word-fall-through FIFO and marks every FRAME_LEN-th beat with TLAST.
module adc_axis_packer #(
    parameter int CH_NUM     = 2,
    parameter int SAMPLE_W   = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 256,
    parameter int IN_W       = CH_NUM * SAMPLE_W,
    parameter int OUT_W      = IN_W * PACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic [IN_W-1:0]  adc_data,
    input  logic             adc_valid,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             overflow
);
    localparam int PIDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    logic                en_prev_q, en_prev_d;
    logic                mode_q, mode_d;
    logic [SAMPLE_W-1:0] ramp_q, ramp_d;
    logic [PIDX_W-1:0]   pack_idx_q, pack_idx_d;
    logic [OUT_W-1:0]    pack_buf_q, pack_buf_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                overflow_q, overflow_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [OUT_W:0]      mem_q [FIFO_DEPTH];

    logic                mode_eff;
    logic                take;
    logic                last_word;
    logic                pop;
    logic                push_ok;
    logic [IN_W-1:0]     ramp_word;
    logic [IN_W-1:0]     word;
    logic [OUT_W-1:0]    beat_next;
    logic                tlast_in;

    always_comb begin
        // The enable rising edge uses the incoming mode so the very first word already follows it.
        mode_eff  = (enable && !en_prev_q) ? mode : mode_q;
        mode_d    = mode_eff;
        en_prev_d = enable;
        take      = enable && (mode_eff || adc_valid);

        ramp_word = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            ramp_word[c*SAMPLE_W +: SAMPLE_W] = ramp_q + SAMPLE_W'(c);
        end
        word   = mode_eff ? ramp_word : adc_data;
        ramp_d = (take && mode_eff) ? ramp_q + SAMPLE_W'(1) : ramp_q;

        beat_next = pack_buf_q;
        beat_next[pack_idx_q*IN_W +: IN_W] = word;
        pack_buf_d = take ? beat_next : pack_buf_q;

        last_word  = take && (pack_idx_q == PIDX_W'(PACK - 1));
        pack_idx_d = pack_idx_q;
        if (take) begin
            pack_idx_d = last_word ? '0 : pack_idx_q + PIDX_W'(1);
        end

        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        pop      = (count_q != '0) && m_axis_tready;
        push_ok  = last_word && ((count_q < (PTR_W+1)'(FIFO_DEPTH)) || pop);
        tlast_in = (beat_cnt_q == CNT_W'(FRAME_LEN - 1));

        beat_cnt_d = beat_cnt_q;
        if (push_ok) begin
            beat_cnt_d = tlast_in ? '0 : beat_cnt_q + CNT_W'(1);
        end
        overflow_d = overflow_q || (last_word && !push_ok);

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_prev_q  <= 1'b0;
            mode_q     <= 1'b0;
            ramp_q     <= '0;
            pack_idx_q <= '0;
            pack_buf_q <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            en_prev_q  <= en_prev_d;
            mode_q     <= mode_d;
            ramp_q     <= ramp_d;
            pack_idx_q <= pack_idx_d;
            pack_buf_q <= pack_buf_d;
            beat_cnt_q <= beat_cnt_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= {tlast_in, beat_next};
        end
    end

    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q][OUT_W-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid ? mem_q[rd_ptr_q][OUT_W] : 1'b0;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_adc_axis_packer.sv
// Scoreboard bench for adc_axis_packer: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every beat the DUT hands over.
module tb_adc_axis_packer;
    localparam int CH_NUM     = 2;
    localparam int SAMPLE_W   = 8;
    localparam int PACK       = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int FRAME_LEN  = 4;
    localparam int IN_W       = 16;
    localparam int OUT_W      = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             mode;
    logic [IN_W-1:0]  adc_data;
    logic             adc_valid;
    logic [OUT_W-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic             overflow;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [OUT_W:0] sb_q[$];

    logic       m_prev_en = 1'b0;
    logic       m_mode    = 1'b0;
    logic [7:0] m_ramp    = 8'd0;
    int         m_idx     = 0;
    logic [OUT_W-1:0] m_beat = '0;
    int         m_cnt     = 0;

    logic             stall_prev = 1'b0;
    logic [OUT_W-1:0] hold_data;
    logic             hold_last;

    adc_axis_packer #(
        .CH_NUM(CH_NUM), .SAMPLE_W(SAMPLE_W), .PACK(PACK),
        .FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs and advances the expected model for the coming edge.
    task automatic apply_stimulus(input logic en, input logic md, input logic [15:0] data,
                                  input logic vld, input logic rdy, input logic rs);
        logic [7:0]  r1;
        logic [15:0] w;
        logic        take;
        enable = en; mode = md; adc_data = data; adc_valid = vld;
        m_axis_tready = rdy; rst = rs;
        if (rs) begin
            m_prev_en = 1'b0; m_mode = 1'b0; m_ramp = 8'd0; m_idx = 0; m_cnt = 0;
            sb_q.delete();
        end else begin
            if (en && !m_prev_en) m_mode = md;
            m_prev_en = en;
            take = en && (m_mode || vld);
            if (take) begin
                r1 = m_ramp + 8'd1;
                w  = m_mode ? {r1, m_ramp} : data;
                if (m_mode) m_ramp = r1;
                m_beat[m_idx*16 +: 16] = w;
                if (m_idx == PACK - 1) begin
                    m_idx = 0;
                    if (sb_q.size() < FIFO_DEPTH || rdy) begin
                        sb_q.push_back({(m_cnt == FRAME_LEN - 1), m_beat});
                        m_cnt = (m_cnt == FRAME_LEN - 1) ? 0 : m_cnt + 1;
                    end
                end else begin
                    m_idx++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || m_axis_tvalid) && n < 100) begin
            apply_stimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        check_output("drain_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check_output("drain_queue", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [OUT_W:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_output("hold_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
                check_output("hold_tdata", m_axis_tdata, hold_data);
                check_output("hold_tlast", {63'd0, m_axis_tlast}, {63'd0, hold_last});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                pops++;
                if (sb_q.size() == 0) begin
                    check_output("unexpected_beat", m_axis_tdata, 64'd0);
                    if (m_axis_tdata == 64'd0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_beat: got=%h want=none", m_axis_tdata);
                    end
                end else begin
                    e = sb_q.pop_front();
                    check_output("beat_tdata", m_axis_tdata, e[OUT_W-1:0]);
                    check_output("beat_tlast", {63'd0, m_axis_tlast}, {63'd0, e[OUT_W]});
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            hold_data  = m_axis_tdata;
            hold_last  = m_axis_tlast;
        end
    end

    initial begin
        int p0;
        apply_stimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check_output("rst_tdata", m_axis_tdata, 64'd0);
        check_output("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check_output("rst_overflow", {63'd0, overflow}, 64'd0);

        // Ramp mode with free-flowing output: 12 beats, TLAST on beats 3, 7, 11.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("first_tvalid_early", {63'd0, m_axis_tvalid}, 64'd0);
        apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("first_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check_output("ramp_beat0", m_axis_tdata, 64'h0403_0302_0201_0100);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("ramp_beat1", m_axis_tdata, 64'h0807_0706_0605_0504);
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);

        // Enable dropped mid-beat must not create a gap or duplicate.
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("gap_beat", m_axis_tdata, 64'h3433_3332_3231_3130);

        // Run the ramp through its 8-bit wrap (words 52..259).
        for (int i = 0; i < 208; i++) begin
            apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
            if (i == 203) check_output("wrap_beat", m_axis_tdata, 64'h00FF_FFFE_FEFD_FDFC);
            if (i == 207) check_output("after_wrap", m_axis_tdata, 64'h0403_0302_0201_0100);
        end
        drain();

        // ADC data on alternate cycles; toggling mode while enabled is ignored.
        apply_stimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            apply_stimulus(1'b1, n[0], {8'(2*n+1), 8'(2*n)}, 1'b1, 1'b1, 1'b0);
            if (n == 3) check_output("adc_beat0", m_axis_tdata, 64'h0706_0504_0302_0100);
            if (n == 7) check_output("adc_beat1", m_axis_tdata, 64'h0F0E_0D0C_0B0A_0908);
            apply_stimulus(1'b1, ~n[0], 16'hBEEF, 1'b0, 1'b1, 1'b0);
        end
        drain();

        // Blocked output: 17 beats produced, 16 kept, overflow sticks.
        apply_stimulus(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check_output("ovf_before", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        check_output("ovf_after", {63'd0, overflow}, 64'd1);
        p0 = pops;
        drain();
        check_output("ovf_drain_count", 64'(pops - p0), 64'd16);
        check_output("ovf_sticky", {63'd0, overflow}, 64'd1);

        // Reset mid-beat discards the partial beat and restarts the ramp.
        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b1);
        check_output("rst2_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check_output("rst2_overflow", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("rst2_beat", m_axis_tdata, 64'h0403_0302_0201_0100);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
